// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage and the data memory.
// Request side is held stable until the one-cycle ack strobe.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: word loads/stores with stall until mem_ack.
// Optional access timeout and sticky fault enabled by MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_readmem,
    input  logic        ex_mem_writemem,
    input  logic [31:0] ex_mem_regb,
    input  logic        ex_mem_selwsource,
    input  logic [4:0]  ex_mem_regdest,
    input  logic        ex_mem_writereg,
    input  logic [31:0] ex_mem_wbvalue,
    output logic        mem_stall,
    mem_stage_if.master mem,
    output logic [4:0]  mem_wb_regdest,
    output logic        mem_wb_writereg,
    output logic [31:0] mem_wb_wbvalue,
    output logic        mem_fault
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_chk
        $error("TIMEOUT_CYCLES out of range");
    end

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_n;
    logic        req_q, req_n;
    logic        we_q, we_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [4:0]  cap_rd_q, cap_rd_n;
    logic        cap_wr_q, cap_wr_n;
    logic        cap_sel_q, cap_sel_n;
    logic [31:0] cap_val_q, cap_val_n;
    logic [4:0]  wb_rd_q, wb_rd_n;
    logic        wb_wr_q, wb_wr_n;
    logic [31:0] wb_val_q, wb_val_n;
`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt_q, cnt_n;
    logic        fault_q, fault_n;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            cap_rd_q  <= 5'h0;
            cap_wr_q  <= 1'b0;
            cap_sel_q <= 1'b0;
            cap_val_q <= 32'h0;
            wb_rd_q   <= 5'h0;
            wb_wr_q   <= 1'b0;
            wb_val_q  <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= 8'h0;
            fault_q   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            req_q     <= req_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            cap_rd_q  <= cap_rd_n;
            cap_wr_q  <= cap_wr_n;
            cap_sel_q <= cap_sel_n;
            cap_val_q <= cap_val_n;
            wb_rd_q   <= wb_rd_n;
            wb_wr_q   <= wb_wr_n;
            wb_val_q  <= wb_val_n;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_n;
            fault_q   <= fault_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        req_n     = req_q;
        we_n      = we_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        cap_rd_n  = cap_rd_q;
        cap_wr_n  = cap_wr_q;
        cap_sel_n = cap_sel_q;
        cap_val_n = cap_val_q;
        wb_rd_n   = wb_rd_q;
        wb_wr_n   = wb_wr_q;
        wb_val_n  = wb_val_q;
`ifdef MEM_TIMEOUT_EN
        cnt_n     = cnt_q;
        fault_n   = fault_q;
`endif
        unique case (state)
            IDLE: begin
                if (ex_mem_readmem || ex_mem_writemem) begin
                    state_n   = WAIT;
                    req_n     = 1'b1;
                    we_n      = ex_mem_writemem;
                    addr_n    = ex_mem_wbvalue;
                    wdata_n   = ex_mem_regb;
                    cap_rd_n  = ex_mem_regdest;
                    cap_wr_n  = ex_mem_writereg;
                    cap_sel_n = ex_mem_selwsource;
                    cap_val_n = ex_mem_wbvalue;
                    wb_wr_n   = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_n     = 8'h0;
`endif
                end else begin
                    wb_rd_n  = ex_mem_regdest;
                    wb_wr_n  = ex_mem_writereg;
                    wb_val_n = ex_mem_wbvalue;
                end
            end
            WAIT: begin
                if (mem.mem_ack) begin
                    state_n  = IDLE;
                    req_n    = 1'b0;
                    wb_rd_n  = cap_rd_q;
                    wb_wr_n  = cap_wr_q;
                    wb_val_n = cap_sel_q ? mem.mem_rdata : cap_val_q;
                end else begin
                    wb_wr_n = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    // Last permitted WAIT cycle without ack: abandon access.
                    if (cnt_q == CNT_LAST) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                        fault_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q + 8'h1;
                    end
`endif
                end
            end
        endcase
    end

    assign mem_stall       = (state == WAIT);
    assign mem.mem_req     = req_q;
    assign mem.mem_we      = we_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wdata   = wdata_q;
    assign mem_wb_regdest  = wb_rd_q;
    assign mem_wb_writereg = wb_wr_q;
    assign mem_wb_wbvalue  = wb_val_q;
`ifdef MEM_TIMEOUT_EN
    assign mem_fault = fault_q;
`else
    assign mem_fault = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles spent in WAIT without mem_ack (1..255, used only with MEM_TIMEOUT_EN).
REQ-002 clock  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 ex_mem_readmem  in  1  load request from execute.
REQ-005 ex_mem_writemem  in  1  store request from execute.
REQ-006 ex_mem_regb  in  32  store data.
REQ-007 ex_mem_selwsource  in  1  1 = writeback from memory read data, 0 = from ex_mem_wbvalue.
REQ-008 ex_mem_regdest  in  5  destination register.
REQ-009 ex_mem_writereg  in  1  register write enable.
REQ-010 ex_mem_wbvalue  in  32  ALU/shift result; also the memory address.
REQ-011 mem_stall  out  1  hold upstream; upstream keeps ex_mem_* stable while high.
REQ-012 mem_req  out  1  data-memory request.
REQ-013 mem_we  out  1  1 = write, 0 = read.
REQ-014 mem_addr  out  32  memory address.
REQ-015 mem_wdata  out  32  memory write data.
REQ-016 mem_rdata  in  32  memory read data, valid when mem_ack high.
REQ-017 mem_ack  in  1  one-cycle completion strobe from memory.
REQ-018 mem_wb_regdest  out  5  writeback destination.
REQ-019 mem_wb_writereg  out  1  writeback enable.
REQ-020 mem_wb_wbvalue  out  32  writeback value.
REQ-021 mem_fault  out  1  sticky timeout flag.

Function
REQ-022 FSM states: IDLE, WAIT; mem_stall = (state == WAIT), decoded from the state register only.
REQ-023 ex_mem_* sampled only in IDLE; ignored in WAIT.
REQ-024 IDLE, no memory op: next edge mem_wb_regdest/writereg/wbvalue <= ex_mem_regdest/writereg/wbvalue; stay IDLE (1-cycle latency).
REQ-025 IDLE, readmem or writemem: next edge state <= WAIT, mem_req <= 1, mem_addr <= ex_mem_wbvalue, mem_wdata <= ex_mem_regb, mem_we <= ex_mem_writemem; capture regdest, writereg, selwsource, wbvalue; mem_wb_writereg <= 0.
REQ-026 readmem and writemem both high: treated as store (mem_we = 1).
REQ-027 WAIT, mem_ack low: mem_req, mem_addr, mem_wdata, mem_we held; mem_wb_writereg <= 0 each edge.
REQ-028 WAIT, mem_ack high: next edge state <= IDLE, mem_req <= 0, mem_wb_regdest <= captured regdest, mem_wb_writereg <= captured writereg, mem_wb_wbvalue <= (captured selwsource ? mem_rdata : captured wbvalue).
REQ-029 Minimum load/store latency: request issued edge N, ack sampled at edge N+1 earliest; stage accepts next instruction at edge N+2.
REQ-030 mem_ack while IDLE ignored; no output change.
REQ-031 mem_rdata used only on the ack edge; no sign/byte manipulation (32-bit word access only).

Reset
REQ-032 reset high at an edge: state <= IDLE; mem_req, mem_we, mem_wb_writereg, mem_fault <= 0; mem_addr, mem_wdata, mem_wb_wbvalue <= 32'h0; mem_wb_regdest <= 5'h0; timeout counter <= 0.
REQ-033 Reset in WAIT aborts the access; a mem_ack arriving after reset is ignored per REQ-030.
REQ-034 Reset has priority over mem_ack and over all ex_mem_* inputs.

Configuration
REQ-035 Macro MEM_TIMEOUT_EN defined: 8-bit counter clears on WAIT entry and increments each WAIT cycle without ack; when the count reaches TIMEOUT_CYCLES without ack, next edge state <= IDLE, mem_req <= 0, mem_wb_writereg <= 0, mem_fault <= 1 (sticky until reset); ack on the same edge as timeout wins (normal completion).
REQ-036 MEM_TIMEOUT_EN undefined: no counter; WAIT persists until mem_ack; mem_fault tied to 0.

Verification
REQ-037 Non-memory op: regdest=5, writereg=1, wbvalue=32'h1234 in IDLE -> next edge mem_wb = (5, 1, 32'h1234); mem_stall stays 0.
REQ-038 Load: wbvalue=32'h100, selwsource=1, regdest=7; ack 3 cycles after mem_req rises with rdata=32'hDEADBEEF -> mem_addr=32'h100, mem_we=0, mem_stall high 3 cycles, then mem_wb = (7, 1, 32'hDEADBEEF), mem_req low.
REQ-039 Store: wbvalue=32'h200, regb=32'hCAFE, writereg=0; ack after 1 cycle -> mem_we=1, mem_wdata=32'hCAFE; mem_wb_writereg stays 0.
REQ-040 Reset asserted in WAIT, then ack pulsed -> all outputs at reset values, state IDLE, no writeback.
REQ-041 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 WAIT cycles, mem_fault=1 and stays 1 until reset; without macro, mem_req held 50 cycles, mem_fault=0.
